// File: rtl/fifo_ctrl.sv
// Synchronous FIFO controller driving an external dual-port RAM.
// Port A writes, port B reads with one cycle of registered latency.
module fifo_ctrl #(
   parameter int unsigned DATA     = 16,
   parameter int unsigned ADDR     = 5,
   parameter int unsigned AF_LEVEL = 28
) (
   input  logic            clK,
   input  logic            rST,
   input  logic            wr_EN,
   input  logic [DATA-1:0] wr_DATA,
   input  logic            rd_EN,
   output logic [DATA-1:0] rd_DATA,
   output logic            rd_VALID,
   output logic            full,
   output logic            empty,
   output logic            almost_FULL,
   output logic [ADDR:0]   count,
   output logic            wr_ERR,
   output logic            rd_ERR,
   output logic            a_port_WR,
   output logic [ADDR-1:0] a_port_ADDR,
   output logic [DATA-1:0] a_port_data_IN,
   output logic            b_port_WR,
   output logic [ADDR-1:0] b_port_ADDR,
   output logic [DATA-1:0] b_port_data_IN,
   input  logic [DATA-1:0] b_port_data_OUT
);

   localparam logic [ADDR:0] Depth   = {1'b1, {ADDR{1'b0}}};
   localparam logic [ADDR:0] AfLevel = AF_LEVEL[ADDR:0];
   localparam logic [ADDR:0] One     = {{ADDR{1'b0}}, 1'b1};

   logic [ADDR:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR:0] count_q, count_d;
   logic          empty_q, empty_d;
   logic          full_q, full_d;
   logic          af_q, af_d;
   logic          rd_valid_q, wr_err_q, rd_err_q;
   logic          wr_acc, rd_acc;

   // Gating on the registered flags keeps read and write on distinct addresses.
   assign wr_acc = wr_EN & ~full_q;
   assign rd_acc = rd_EN & ~empty_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + One;
      end
      if (rd_acc) begin
         rd_ptr_d = rd_ptr_q + One;
      end
      unique case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + One;
         2'b01:   count_d = count_q - One;
         default: count_d = count_q;
      endcase
      empty_d = (count_d == '0);
      full_d  = (count_d == Depth);
      af_d    = (count_d >= AfLevel);
   end

   always_ff @(posedge clK or posedge rST) begin
      if (rST) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         empty_q    <= 1'b1;
         full_q     <= 1'b0;
         af_q       <= 1'b0;
         rd_valid_q <= 1'b0;
         wr_err_q   <= 1'b0;
         rd_err_q   <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         empty_q    <= empty_d;
         full_q     <= full_d;
         af_q       <= af_d;
         rd_valid_q <= rd_acc;
         wr_err_q   <= wr_EN & full_q;
         rd_err_q   <= rd_EN & empty_q;
      end
   end

   assign a_port_WR      = wr_acc & ~rST;
   assign a_port_ADDR    = wr_ptr_q[ADDR-1:0];
   assign a_port_data_IN = wr_DATA;
   assign b_port_WR      = 1'b0;
   assign b_port_ADDR    = rd_ptr_q[ADDR-1:0];
   assign b_port_data_IN = '0;

   assign rd_DATA     = b_port_data_OUT;
   assign rd_VALID    = rd_valid_q;
   assign full        = full_q;
   assign empty       = empty_q;
   assign almost_FULL = af_q;
   assign count       = count_q;
   assign wr_ERR      = wr_err_q;
   assign rd_ERR      = rd_err_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Randomised bench for fifo_ctrl with a behavioural RAM and a queue-based FIFO model.
module tb_fifo_ctrl;

   localparam int Depth = 32;
   localparam int AfLvl = 28;

   logic        clK = 1'b0;
   logic        rST = 1'b1;
   logic        wr_EN = 1'b0;
   logic [15:0] wr_DATA = '0;
   logic        rd_EN = 1'b0;
   logic [15:0] rd_DATA;
   logic        rd_VALID, full, empty, almost_FULL, wr_ERR, rd_ERR;
   logic [5:0]  count;
   logic        a_port_WR, b_port_WR;
   logic [4:0]  a_port_ADDR, b_port_ADDR;
   logic [15:0] a_port_data_IN, b_port_data_IN;
   logic [15:0] b_port_data_OUT;

   logic [15:0] ram_mem [Depth];

   int n_checks = 0;
   int n_fail   = 0;

   // Model state
   logic [15:0] mq[$];
   int          waddr = 0;
   int          raddr = 0;
   logic        exp_valid, exp_werr, exp_rerr, exp_awr;
   logic [15:0] exp_rd;
   int          exp_aaddr, exp_baddr;
   logic        obs_awr;
   logic [4:0]  obs_aaddr, obs_baddr;
   logic [15:0] obs_adata;

   fifo_ctrl dut (
      .clK             (clK),
      .rST             (rST),
      .wr_EN           (wr_EN),
      .wr_DATA         (wr_DATA),
      .rd_EN           (rd_EN),
      .rd_DATA         (rd_DATA),
      .rd_VALID        (rd_VALID),
      .full            (full),
      .empty           (empty),
      .almost_FULL     (almost_FULL),
      .count           (count),
      .wr_ERR          (wr_ERR),
      .rd_ERR          (rd_ERR),
      .a_port_WR       (a_port_WR),
      .a_port_ADDR     (a_port_ADDR),
      .a_port_data_IN  (a_port_data_IN),
      .b_port_WR       (b_port_WR),
      .b_port_ADDR     (b_port_ADDR),
      .b_port_data_IN  (b_port_data_IN),
      .b_port_data_OUT (b_port_data_OUT)
   );

   always #5 clK = ~clK;

   always_ff @(posedge clK) begin
      if (a_port_WR) ram_mem[a_port_ADDR] <= a_port_data_IN;
      b_port_data_OUT <= ram_mem[b_port_ADDR];
   end

   // Drives one cycle, samples the RAM-side outputs before the edge, advances the model.
   task automatic cyc(input logic w, input logic [15:0] d, input logic r);
      logic acc_w, acc_r;
      @(negedge clK);
      wr_EN = w; wr_DATA = d; rd_EN = r;
      #1;
      obs_awr = a_port_WR; obs_aaddr = a_port_ADDR; obs_adata = a_port_data_IN;
      obs_baddr = b_port_ADDR;
      acc_w = w && (mq.size() < Depth);
      acc_r = r && (mq.size() > 0);
      exp_awr = acc_w; exp_aaddr = waddr; exp_baddr = raddr;
      if (acc_r) begin
         exp_rd = mq.pop_front();
         raddr = (raddr + 1) % Depth;
      end
      if (acc_w) begin
         mq.push_back(d);
         waddr = (waddr + 1) % Depth;
      end
      exp_valid = acc_r; exp_werr = w && !acc_w; exp_rerr = r && !acc_r;
      @(posedge clK);
      #1;
   endtask

   task automatic apply_reset();
      @(negedge clK);
      wr_EN = 1'b0; rd_EN = 1'b0; rST = 1'b1;
      mq.delete(); waddr = 0; raddr = 0;
      @(negedge clK);
      rST = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clK);
      wr_EN = 1'b1; wr_DATA = 16'h1234;
      #1;
      n_checks++;
      if ({count, empty, full, almost_FULL} !== {6'd0, 1'b1, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_flags: got count=%0d e=%b f=%b af=%b, need 0 1 0 0",
                  count, empty, full, almost_FULL);
      end
      n_checks++;
      if ({rd_VALID, wr_ERR, rd_ERR} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_pulses: got v/we/re=%b%b%b, need 000", rd_VALID, wr_ERR, rd_ERR);
      end
      n_checks++;
      if (a_port_WR !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_awr: got %b, need 0", a_port_WR);
      end
      n_checks++;
      if ({b_port_WR, b_port_data_IN, b_port_ADDR} !== 22'd0) begin
         n_fail++;
         $display("FAIL reset_bport: got wr=%b din=%h addr=%0d, need 0 0 0",
                  b_port_WR, b_port_data_IN, b_port_ADDR);
      end
      wr_EN = 1'b0;
      @(negedge clK);
      rST = 1'b0;
   endtask

   task automatic test_basic();
      for (int i = 1; i <= 3; i++) cyc(1'b1, 16'(i), 1'b0);
      for (int i = 1; i <= 3; i++) begin
         cyc(1'b0, 16'h0, 1'b1);
         n_checks++;
         if (rd_VALID !== 1'b1 || rd_DATA !== 16'(i)) begin
            n_fail++;
            $display("FAIL basic_read%0d: got v=%b data=%h, need 1 %h", i, rd_VALID, rd_DATA, 16'(i));
         end
      end
      n_checks++;
      if (empty !== 1'b1 || count !== 6'd0) begin
         n_fail++;
         $display("FAIL basic_end: got e=%b count=%0d, need 1 0", empty, count);
      end
      cyc(1'b0, 16'h0, 1'b0);
      n_checks++;
      if (rd_VALID !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_valid_drop: got %b, need 0", rd_VALID);
      end
   endtask

   task automatic test_empty_read();
      cyc(1'b0, 16'h0, 1'b1);
      n_checks++;
      if (rd_ERR !== 1'b1 || rd_VALID !== 1'b0) begin
         n_fail++;
         $display("FAIL empty_read: got re=%b v=%b, need 1 0", rd_ERR, rd_VALID);
      end
      n_checks++;
      if (int'(b_port_ADDR) !== raddr) begin
         n_fail++;
         $display("FAIL empty_read_ptr: got %0d, need %0d", b_port_ADDR, raddr);
      end
      cyc(1'b0, 16'h0, 1'b0);
      n_checks++;
      if (rd_ERR !== 1'b0) begin
         n_fail++;
         $display("FAIL empty_read_pulse: got %b, need 0", rd_ERR);
      end
   endtask

   task automatic test_fill();
      logic [15:0] first;
      apply_reset();
      for (int i = 0; i < Depth; i++) begin
         logic [15:0] d;
         d = 16'($urandom);
         if (i == 0) first = d;
         cyc(1'b1, d, 1'b0);
         n_checks++;
         if (obs_awr !== 1'b1 || int'(obs_aaddr) !== exp_aaddr || obs_adata !== d) begin
            n_fail++;
            $display("FAIL fill_port%0d: got wr=%b addr=%0d d=%h, need 1 %0d %h",
                     i, obs_awr, obs_aaddr, obs_adata, exp_aaddr, d);
         end
         n_checks++;
         if (int'(count) !== mq.size() || almost_FULL !== (mq.size() >= AfLvl) ||
             full !== (mq.size() == Depth)) begin
            n_fail++;
            $display("FAIL fill_flags%0d: got count=%0d af=%b f=%b, need %0d %b %b", i, count,
                     almost_FULL, full, mq.size(), mq.size() >= AfLvl, mq.size() == Depth);
         end
      end
      cyc(1'b1, ~first, 1'b0);
      n_checks++;
      if (wr_ERR !== 1'b1 || obs_awr !== 1'b0 || count !== 6'd32 || full !== 1'b1) begin
         n_fail++;
         $display("FAIL overflow: got we=%b awr=%b count=%0d f=%b, need 1 0 32 1",
                  wr_ERR, obs_awr, count, full);
      end
      n_checks++;
      if (ram_mem[0] !== first) begin
         n_fail++;
         $display("FAIL overflow_ram0: got %h, need %h", ram_mem[0], first);
      end
      cyc(1'b0, 16'h0, 1'b0);
      n_checks++;
      if (wr_ERR !== 1'b0) begin
         n_fail++;
         $display("FAIL overflow_pulse: got %b, need 0", wr_ERR);
      end
   endtask

   task automatic test_full_simul();
      cyc(1'b1, 16'hDEAD, 1'b1);
      n_checks++;
      if (rd_VALID !== 1'b1 || rd_DATA !== exp_rd || wr_ERR !== 1'b1 || count !== 6'd31) begin
         n_fail++;
         $display("FAIL full_simul: got v=%b d=%h we=%b count=%0d, need 1 %h 1 31",
                  rd_VALID, rd_DATA, wr_ERR, count, exp_rd);
      end
      while (mq.size() > 10) begin
         cyc(1'b0, 16'h0, 1'b1);
         n_checks++;
         if (rd_VALID !== 1'b1 || rd_DATA !== exp_rd) begin
            n_fail++;
            $display("FAIL drain: got v=%b d=%h, need 1 %h", rd_VALID, rd_DATA, exp_rd);
         end
      end
      for (int i = 0; i < 40; i++) begin
         cyc(1'b1, 16'($urandom), 1'b1);
         n_checks++;
         if (count !== 6'd10 || rd_VALID !== 1'b1 || rd_DATA !== exp_rd) begin
            n_fail++;
            $display("FAIL steady%0d: got count=%0d v=%b d=%h, need 10 1 %h",
                     i, count, rd_VALID, rd_DATA, exp_rd);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 500; i++) begin
         logic w, r;
         // Shift the write bias so occupancy sweeps both empty and full.
         w = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 70 : 30));
         r = ($urandom_range(0, 99) < 50);
         cyc(w, 16'($urandom), r);
         n_checks++;
         if (int'(count) !== mq.size() || empty !== (mq.size() == 0) ||
             full !== (mq.size() == Depth) || almost_FULL !== (mq.size() >= AfLvl)) begin
            n_fail++;
            $display("FAIL rand_flags%0d: got c=%0d e=%b f=%b af=%b, need %0d %b %b %b", i,
                     count, empty, full, almost_FULL, mq.size(), mq.size() == 0,
                     mq.size() == Depth, mq.size() >= AfLvl);
         end
         n_checks++;
         if (rd_VALID !== exp_valid || wr_ERR !== exp_werr || rd_ERR !== exp_rerr ||
             (exp_valid && rd_DATA !== exp_rd)) begin
            n_fail++;
            $display("FAIL rand_out%0d: got v=%b d=%h we=%b re=%b, need %b %h %b %b", i,
                     rd_VALID, rd_DATA, wr_ERR, rd_ERR, exp_valid, exp_rd, exp_werr, exp_rerr);
         end
         n_checks++;
         if (obs_awr !== exp_awr || int'(obs_aaddr) !== exp_aaddr ||
             int'(obs_baddr) !== exp_baddr) begin
            n_fail++;
            $display("FAIL rand_ram%0d: got awr=%b aa=%0d ba=%0d, need %b %0d %0d", i,
                     obs_awr, obs_aaddr, obs_baddr, exp_awr, exp_aaddr, exp_baddr);
         end
      end
   endtask

   task automatic test_async_reset();
      apply_reset();
      for (int i = 0; i < 6; i++) cyc(1'b1, 16'(16'hA0 + i), 1'b0);
      cyc(1'b0, 16'h0, 1'b1);
      n_checks++;
      if (rd_VALID !== 1'b1 || count !== 6'd5) begin
         n_fail++;
         $display("FAIL pre_areset: got v=%b count=%0d, need 1 5", rd_VALID, count);
      end
      rd_EN = 1'b0;
      #2 rST = 1'b1;
      mq.delete(); waddr = 0; raddr = 0;
      #1;
      n_checks++;
      if (rd_VALID !== 1'b0 || empty !== 1'b1 || count !== 6'd0) begin
         n_fail++;
         $display("FAIL areset: got v=%b e=%b count=%0d, need 0 1 0", rd_VALID, empty, count);
      end
      @(negedge clK);
      rST = 1'b0;
      cyc(1'b1, 16'hBEEF, 1'b0);
      cyc(1'b0, 16'h0, 1'b1);
      n_checks++;
      if (rd_VALID !== 1'b1 || rd_DATA !== 16'hBEEF || empty !== 1'b1) begin
         n_fail++;
         $display("FAIL post_areset: got v=%b d=%h e=%b, need 1 beef 1", rd_VALID, rd_DATA, empty);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_empty_read();
      test_fill();
      test_full_simul();
      test_random();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
